fpu_arbiter: RTL and testbench
==============================

# fpu_arbiter

Issue controller that shares the single `fpu` datapath between two requesters (e.g. the FP issue port and the conversion/move path). It arbitrates round-robin, latches one operation, drives the FPU's operand and opcode inputs stable until the FPU signals `fin`, and returns the result with the requester's tag. It sits between the decode/issue stage and the `fpu` instance. It also supervises a watchdog for a hung operation.

## Interface
- `TIMEOUT`, default 16: EXEC cycles without `fpu_fin` before abort; must be > 10.
- `TAGW`, default 5: width of destination tag.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset. The integrator drives `fpu`'s `rstn` from `~rst`.
- `req_valid`  in  2  per-requester request.
- `req_ready`  out  2  per-requester accept. A request is accepted when `req_valid[i] & req_ready[i]`.
- `req_op`  in  2x4  fpuop encoding: 0000 fadd, 0001 fsub, 0010 fmul, 0011 fdiv, 0100 fsqrt, 0101–0111 fsgnj/n/x, 1000–1010 feq/fle/flt, 1011 fcvt.w.s, 1100 fcvt.s.w.
- `req_src0`, `req_src1`  in  2x32  operands.
- `req_tag`  in  2xTAGW  destination tag.
- `rsp_valid`  out  2  one-cycle result strobe to the owning requester. There is no backpressure.
- `rsp_data`  out  32  result.
- `rsp_tag`  out  TAGW  tag of the returned operation.
- `fpu_src0`, `fpu_src1`  out  32  to `fpu`.
- `fpu_op`  out  4  to `fpu`.
- `fpu_result`  in  32  from `fpu`.
- `fpu_fin`  in  1  from `fpu`. It is combinational in `fpu`.
- `busy`  out  1  high in EXEC.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- States:
  - IDLE: accepts requests; `fpu_op`=NOP.
  - EXEC: the FPU is running the latched operation.
  - RESP: `rsp_valid` is high; accepts requests; `fpu_op`=NOP.
- NOP is 4'b1111. In `fpu`, NOP yields `fin`=1 and does not advance the FPU's internal counter.
- Arbitration: a last-grant pointer `lp`, reset to 1 so requester 0 wins first.
  - If both requesters are valid, grant `~lp`. Otherwise grant the single valid requester.
  - `req_ready[i]` = (state ∈ {IDLE, RESP}) & grant[i].
  - At most one bit of `req_ready` is high.
  - `lp` updates only on acceptance.
  - `req_ready` may depend on `req_valid`. Requesters must not gate `req_valid` on `req_ready`.
- Acceptance: latch op, src0, src1, tag and the owner index into holding registers; next state EXEC.
- EXEC:
  - `fpu_op`/`fpu_src*` are driven from the holding registers and held constant.
  - `wd` counts cycles in EXEC, starting from 0.
  - If `fpu_fin`=1: capture `fpu_result` into `rsp_data`; next state RESP.
  - Else if `wd`==TIMEOUT-1: `rsp_data`←0, set `timeout_err`; next state RESP.
- RESP:
  - `rsp_valid[owner]`=1 and `rsp_tag`=latched tag, both for exactly one cycle.
  - Next state is EXEC if a new request is accepted this cycle, else IDLE.
- Opcodes 1101–1111 from requesters are legal. They complete in zero FPU latency with result 0.
- `fpu_src*` hold their last value outside EXEC.

## Timing
- Reset values: state IDLE, `req_ready`=00 during reset, `rsp_valid`=00, `rsp_data`=0, `rsp_tag`=0, `busy`=0, `timeout_err`=0, `lp`=1, `fpu_op`=NOP.
- Accept at cycle T → EXEC from T+1. `fpu_fin` rises at T+1+L, where L depends on the operation:
  - fadd/fsub/fmul: L=3.
  - fdiv: L=10.
  - fsqrt: L=8.
  - fcvt: L=1.
  - all others: L=0.
- `rsp_valid` is high at T+2+L.
- Back-to-back: the next accept can occur in the RESP cycle (T+2+L), giving EXEC from T+3+L. Throughput is one op per L+2 cycles.
- The FPU counter is 0 at every EXEC entry. It resets on the `fin` edge, and NOP is driven in IDLE/RESP.
- Timeout: EXEC at T+1..T+TIMEOUT, then `rsp_valid` at T+1+TIMEOUT.
- Reset mid-EXEC: discard the operation, emit no response, and return to the reset values next cycle.

## Test plan
- **fadd:** req0 fadd 0x3F800000 + 0x40000000 with tag 7, accepted at T → `rsp_valid`=01 at T+5 only, `rsp_data`=0x40400000, `rsp_tag`=7.
- **fdiv:** req1 fdiv 0x40C00000 / 0x40000000 → `rsp_valid`=10 at T+12, data 0x40400000. `busy` is high T+1..T+11. `req_ready`=00 during EXEC.
- **Contention:** req0 and req1 both valid from reset with fsgnj → req0 accepted first, response 2 cycles later. req1 is accepted in that RESP cycle. Then req0 again, alternating.
- **Zero-latency op:** feq 0x3F800000, 0x3F800000 → `rsp_data`=1 at T+2.
- **Watchdog:** FPU model holds `fin`=0 with op fmul → `rsp_valid` at T+17, `rsp_data`=0, `timeout_err` set and held until `rst`.
- **Reset mid-op:** `rst` asserted at T+4 of an fdiv → no `rsp_valid` ever. Next accept targets requester 0. Normal fadd latency after release.

Source files
------------

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin issue controller that shares one fpu datapath
// between two requesters. One operation is latched at a time, its operands
// and opcode are held on the fpu inputs until fin, and the result is returned
// with the requester's tag. A watchdog aborts an operation that never finishes.
module fpu_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int TAGW    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0][3:0]      req_op,
    input  logic [1:0][31:0]     req_src0,
    input  logic [1:0][31:0]     req_src1,
    input  logic [1:0][TAGW-1:0] req_tag,
    output logic [1:0]           rsp_valid,
    output logic [31:0]          rsp_data,
    output logic [TAGW-1:0]      rsp_tag,
    output logic [31:0]          fpu_src0,
    output logic [31:0]          fpu_src1,
    output logic [3:0]           fpu_op,
    input  logic [31:0]          fpu_result,
    input  logic                 fpu_fin,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam logic [3:0] OP_NOP   = 4'b1111;
    // Opcodes at or above this value are not real fpu operations and
    // complete immediately with a zero result.
    localparam logic [3:0] OP_ZERO  = 4'b1101;
    localparam int         WDW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic              lp_q;          // index of the last granted requester
    logic              owner_q;       // requester owning the latched operation
    logic [TAGW-1:0]   tag_q;
    logic [WDW-1:0]    wd_q;
    logic [3:0]        fpu_op_q;
    logic [31:0]       fpu_src0_q;
    logic [31:0]       fpu_src1_q;
    logic [1:0]        rsp_valid_q;
    logic [31:0]       rsp_data_q;
    logic [TAGW-1:0]   rsp_tag_q;
    logic              busy_q;
    logic              timeout_err_q;

    logic [1:0]        grant_s;
    logic [1:0]        ready_s;
    logic              accept_s;
    logic              sel_s;
    logic              zero_op_s;

    // Round-robin grant: on contention the requester not granted last wins.
    always_comb begin
        grant_s = 2'b00;
        case (req_valid)
            2'b11:   grant_s = lp_q ? 2'b01 : 2'b10;
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            default: grant_s = 2'b00;
        endcase
    end

    // Ready only in the accepting states and never while reset is applied.
    always_comb begin
        ready_s = 2'b00;
        if (!rst && (state_q == S_IDLE || state_q == S_RESP)) begin
            ready_s = grant_s;
        end else begin
            ready_s = 2'b00;
        end
    end

    assign accept_s  = |(req_valid & ready_s);
    assign sel_s     = grant_s[1];
    assign zero_op_s = (fpu_op_q >= OP_ZERO);

    // Main controller: state, holding registers, watchdog and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lp_q          <= 1'b1;
            owner_q       <= 1'b0;
            tag_q         <= '0;
            wd_q          <= '0;
            fpu_op_q      <= OP_NOP;
            fpu_src0_q    <= 32'h0000_0000;
            fpu_src1_q    <= 32'h0000_0000;
            rsp_valid_q   <= 2'b00;
            rsp_data_q    <= 32'h0000_0000;
            rsp_tag_q     <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            rsp_valid_q <= 2'b00;
            rsp_tag_q   <= '0;
            case (state_q)
                S_IDLE, S_RESP: begin
                    if (accept_s) begin
                        state_q    <= S_EXEC;
                        lp_q       <= sel_s;
                        owner_q    <= sel_s;
                        tag_q      <= req_tag[sel_s];
                        fpu_op_q   <= req_op[sel_s];
                        fpu_src0_q <= req_src0[sel_s];
                        fpu_src1_q <= req_src1[sel_s];
                        wd_q       <= '0;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q  <= S_IDLE;
                        fpu_op_q <= OP_NOP;
                        busy_q   <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (zero_op_s || fpu_fin || (wd_q == WD_LAST)) begin
                        state_q     <= S_RESP;
                        fpu_op_q    <= OP_NOP;
                        busy_q      <= 1'b0;
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        rsp_tag_q   <= tag_q;
                        if (zero_op_s) begin
                            rsp_data_q <= 32'h0000_0000;
                        end else if (fpu_fin) begin
                            rsp_data_q <= fpu_result;
                        end else begin
                            rsp_data_q    <= 32'h0000_0000;
                            timeout_err_q <= 1'b1;
                        end
                    end else begin
                        wd_q <= wd_q + {{(WDW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    fpu_op_q <= OP_NOP;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = ready_s;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_tag     = rsp_tag_q;
    assign fpu_op      = fpu_op_q;
    assign fpu_src0    = fpu_src0_q;
    assign fpu_src1    = fpu_src1_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed self-checking bench for fpu_arbiter with a behavioural fpu model.
module tb_fpu_arbiter;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][3:0]   req_op;
    logic [1:0][31:0]  req_src0;
    logic [1:0][31:0]  req_src1;
    logic [1:0][4:0]   req_tag;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_data;
    logic [4:0]        rsp_tag;
    logic [31:0]       fpu_src0;
    logic [31:0]       fpu_src1;
    logic [3:0]        fpu_op;
    logic [31:0]       fpu_result;
    logic              fpu_fin;
    logic              busy;
    logic              timeout_err;

    logic              hang;
    logic [31:0]       model_res;
    logic [3:0]        cnt_q;
    int                n_cmp;
    int                n_mis;

    fpu_arbiter #(.TIMEOUT(16), .TAGW(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src0(req_src0), .req_src1(req_src1), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .fpu_src0(fpu_src0), .fpu_src1(fpu_src1), .fpu_op(fpu_op),
        .fpu_result(fpu_result), .fpu_fin(fpu_fin),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fpu latency table
    function automatic int lat(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h2: lat = 3;
            4'h3:             lat = 10;
            4'h4:             lat = 8;
            4'hB, 4'hC:       lat = 1;
            default:          lat = 0;
        endcase
    endfunction

    // fpu model: fin is combinational on the internal counter
    always_comb begin
        if (hang) fpu_fin = 1'b0;
        else if (fpu_op == 4'hF) fpu_fin = 1'b1;
        else fpu_fin = (int'(cnt_q) == lat(fpu_op));
    end
    assign fpu_result = model_res;

    // fpu model: counter restarts on fin and idles under NOP
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 4'd0;
        else if (fpu_op == 4'hF || fpu_fin) cnt_q <= 4'd0;
        else cnt_q <= cnt_q + 4'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from requester r and follow it to its response.
    task automatic run_op(input string name, input int r, input logic [3:0] op,
                          input logic [31:0] s0, input logic [31:0] s1, input logic [4:0] tag,
                          input logic [31:0] res, input int exp_n, input logic [31:0] exp_data);
        int n;
        logic [1:0] onehot;
        onehot = (r == 1) ? 2'b10 : 2'b01;
        model_res   = res;
        req_valid   = onehot;
        req_op[r]   = op;
        req_src0[r] = s0;
        req_src1[r] = s1;
        req_tag[r]  = tag;
        #1;
        check_eq({name, ".ready"}, 32'(req_ready), 32'(onehot));
        step();
        req_valid = 2'b00;
        n = 1;
        check_eq({name, ".fpu_op"}, 32'(fpu_op), 32'(op));
        check_eq({name, ".fpu_src0"}, fpu_src0, s0);
        check_eq({name, ".fpu_src1"}, fpu_src1, s1);
        while (rsp_valid == 2'b00 && n < 40) begin
            check_eq({name, ".busy"}, 32'(busy), 32'd1);
            req_valid = 2'b11;
            #1;
            check_eq({name, ".ready_exec"}, 32'(req_ready), 32'd0);
            req_valid = 2'b00;
            step();
            n++;
        end
        check_eq({name, ".latency"}, 32'(n), 32'(exp_n));
        check_eq({name, ".rsp_valid"}, 32'(rsp_valid), 32'(onehot));
        check_eq({name, ".rsp_data"}, rsp_data, exp_data);
        check_eq({name, ".rsp_tag"}, 32'(rsp_tag), 32'(tag));
        check_eq({name, ".busy_resp"}, 32'(busy), 32'd0);
        check_eq({name, ".fpu_op_resp"}, 32'(fpu_op), 32'hF);
        step();
        check_eq({name, ".rsp_once"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int seen;
        n_cmp = 0;
        n_mis = 0;
        hang = 1'b0;
        model_res = 32'h0;
        req_op = '0;
        req_src0 = '0;
        req_src1 = '0;
        req_tag = '0;

        // reset state
        rst = 1'b1;
        req_valid = 2'b11;
        step();
        step();
        check_eq("rst.ready", 32'(req_ready), 32'd0);
        check_eq("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst.rsp_data", rsp_data, 32'd0);
        check_eq("rst.rsp_tag", 32'(rsp_tag), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.timeout_err", 32'(timeout_err), 32'd0);
        check_eq("rst.fpu_op", 32'(fpu_op), 32'hF);
        req_valid = 2'b00;
        rst = 1'b0;
        step();

        // contention: fsgnj from both, alternating starting with req0
        model_res = 32'h1122_3344;
        req_op   = {4'h5, 4'h5};
        req_src0 = {32'hB000_0001, 32'hA000_0001};
        req_src1 = {32'hB000_0002, 32'hA000_0002};
        req_tag  = {5'd9, 5'd3};
        req_valid = 2'b11;
        #1;
        check_eq("cont.ready0", 32'(req_ready), 32'd1);
        step();
        check_eq("cont.busy0", 32'(busy), 32'd1);
        check_eq("cont.ready_exec0", 32'(req_ready), 32'd0);
        check_eq("cont.src0_0", fpu_src0, 32'hA000_0001);
        step();
        check_eq("cont.rsp0", 32'(rsp_valid), 32'd1);
        check_eq("cont.tag0", 32'(rsp_tag), 32'd3);
        check_eq("cont.data0", rsp_data, 32'h1122_3344);
        check_eq("cont.ready1", 32'(req_ready), 32'd2);
        step();
        check_eq("cont.busy1", 32'(busy), 32'd1);
        check_eq("cont.src0_1", fpu_src0, 32'hB000_0001);
        step();
        check_eq("cont.rsp1", 32'(rsp_valid), 32'd2);
        check_eq("cont.tag1", 32'(rsp_tag), 32'd9);
        check_eq("cont.ready2", 32'(req_ready), 32'd1);
        req_valid = 2'b00;
        step();
        check_eq("cont.idle_busy", 32'(busy), 32'd0);
        check_eq("cont.idle_op", 32'(fpu_op), 32'hF);

        // single operations of each latency class
        run_op("fadd", 0, 4'h0, 32'h3F80_0000, 32'h4000_0000, 5'd7, 32'h4040_0000, 5, 32'h4040_0000);
        run_op("fdiv", 1, 4'h3, 32'h40C0_0000, 32'h4000_0000, 5'd12, 32'h4040_0000, 12, 32'h4040_0000);
        run_op("feq", 0, 4'h8, 32'h3F80_0000, 32'h3F80_0000, 5'd1, 32'h0000_0001, 2, 32'h0000_0001);
        run_op("fsqrt", 1, 4'h4, 32'h4110_0000, 32'h0, 5'd30, 32'h4040_0000, 10, 32'h4040_0000);
        run_op("fcvt", 0, 4'hB, 32'h4040_0000, 32'h0, 5'd2, 32'h0000_0003, 3, 32'h0000_0003);
        run_op("op_d", 1, 4'hD, 32'h1234_5678, 32'h9ABC_DEF0, 5'd4, 32'hDEAD_BEEF, 2, 32'h0000_0000);
        check_eq("pre_wd.timeout_err", 32'(timeout_err), 32'd0);

        // watchdog
        hang = 1'b1;
        run_op("wd", 0, 4'h2, 32'h4000_0000, 32'h4000_0000, 5'd5, 32'h4080_0000, 17, 32'h0000_0000);
        check_eq("wd.timeout_err", 32'(timeout_err), 32'd1);
        hang = 1'b0;
        run_op("post_wd", 1, 4'h1, 32'h4040_0000, 32'h3F80_0000, 5'd6, 32'h4000_0000, 5, 32'h4000_0000);
        check_eq("post_wd.sticky", 32'(timeout_err), 32'd1);

        // reset in the middle of an fdiv from requester 1
        model_res   = 32'h4040_0000;
        req_valid   = 2'b10;
        req_op[1]   = 4'h3;
        req_src0[1] = 32'h40C0_0000;
        req_src1[1] = 32'h4000_0000;
        req_tag[1]  = 5'd11;
        #1;
        check_eq("rmid.ready", 32'(req_ready), 32'd2);
        step();
        req_valid = 2'b00;
        step();
        step();
        step();
        check_eq("rmid.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        check_eq("rmid.busy", 32'(busy), 32'd0);
        check_eq("rmid.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rmid.timeout_err", 32'(timeout_err), 32'd0);
        check_eq("rmid.fpu_op", 32'(fpu_op), 32'hF);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (rsp_valid != 2'b00) seen++;
            step();
        end
        check_eq("rmid.no_rsp", 32'(seen), 32'd0);
        req_valid = 2'b11;
        #1;
        check_eq("rmid.next_grant", 32'(req_ready), 32'd1);
        req_valid = 2'b00;
        run_op("rmid.fadd", 0, 4'h0, 32'h3F80_0000, 32'h4000_0000, 5'd7, 32'h4040_0000, 5, 32'h4040_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
